// File: rtl/wb_stream_writer_fifo.sv
// First-word-fall-through stream buffer feeding the Wishbone stream write controller.
// Exact registered occupancy count, registered ready, sticky underflow and synchronous flush.
module wb_stream_writer_fifo #(
   parameter int DW      = 32,
   parameter int FIFO_AW = 4
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic [DW-1:0]      stream_s_data_i,
   input  logic               stream_s_valid_i,
   output logic               stream_s_ready_o,
   output logic [DW-1:0]      fifo_d,
   output logic               fifo_dv,
   output logic [FIFO_AW:0]   fifo_cnt,
   input  logic               fifo_rd,
   input  logic               clear,
   output logic               underflow_o
);

   generate
      if (FIFO_AW < 1) begin : g_bad_fifo_aw
         $error("wb_stream_writer_fifo: FIFO_AW must be >= 1");
      end
   endgenerate

   localparam int               DEPTH     = 2**FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_CNT = DEPTH[FIFO_AW:0];
   localparam logic [FIFO_AW:0] ONE       = {{FIFO_AW{1'b0}}, 1'b1};

   logic [DW-1:0]    mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic [FIFO_AW:0] cnt;
   logic [FIFO_AW:0] next_cnt;
   logic             push;
   logic             pop;

   assign push     = stream_s_valid_i & stream_s_ready_o;
   assign pop      = fifo_rd & fifo_dv;
   // Pointers differing in any bit (MSB included) means non-empty; always equal to cnt != 0.
   assign fifo_dv  = (wr_ptr != rd_ptr);
   assign fifo_d   = mem[rd_ptr[FIFO_AW-1:0]];
   assign fifo_cnt = cnt;

   // NOTE: every path through a combinational block assigns its outputs first, so no latch is inferred.
   always_comb begin
      next_cnt = cnt;
      case ({push, pop})
         2'b10:   next_cnt = cnt + ONE;
         2'b01:   next_cnt = cnt - ONE;
         default: next_cnt = cnt;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         cnt              <= '0;
         stream_s_ready_o <= 1'b0;
         underflow_o      <= 1'b0;
      end else if (clear) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         cnt              <= '0;
         stream_s_ready_o <= 1'b1;
         underflow_o      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE;
         if (pop)  rd_ptr <= rd_ptr + ONE;
         cnt              <= next_cnt;
         stream_s_ready_o <= (next_cnt < DEPTH_CNT);
         if (fifo_rd && !fifo_dv) underflow_o <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; contents are only observable once the pointers say they are valid.
   always_ff @(posedge wb_clk_i) begin
      if (push && !clear && !wb_rst_i) mem[wr_ptr[FIFO_AW-1:0]] <= stream_s_data_i;
   end

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// Self-checking bench for wb_stream_writer_fifo (FIFO_AW=2): directed vectors plus a
// scoreboard queue filled on accepted pushes and drained by an independent pop monitor.
module tb_wb_stream_writer_fifo;

   localparam int DW      = 32;
   localparam int FIFO_AW = 2;

   logic              clk;
   logic              rst;
   logic [DW-1:0]     s_data;
   logic              s_valid;
   logic              s_ready;
   logic [DW-1:0]     fifo_d;
   logic              fifo_dv;
   logic [FIFO_AW:0]  fifo_cnt;
   logic              fifo_rd;
   logic              clear;
   logic              underflow;

   int n_checks   = 0;
   int n_failures = 0;
   logic [DW-1:0] exp_q [$];

   wb_stream_writer_fifo #(.DW(DW), .FIFO_AW(FIFO_AW)) dut (
      .wb_clk_i         (clk),
      .wb_rst_i         (rst),
      .stream_s_data_i  (s_data),
      .stream_s_valid_i (s_valid),
      .stream_s_ready_o (s_ready),
      .fifo_d           (fifo_d),
      .fifo_dv          (fifo_dv),
      .fifo_cnt         (fifo_cnt),
      .fifo_rd          (fifo_rd),
      .clear            (clear),
      .underflow_o      (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard writer: record words the DUT accepts; flush on reset or clear.
   always @(negedge clk) begin
      if (rst || clear) exp_q.delete();
      else if (s_valid && s_ready) exp_q.push_back(s_data);
   end

   // Monitor: whenever the consumer pops a presented word, compare it against the oldest expected.
   always @(negedge clk) begin
      #1;
      if (!rst && fifo_rd && fifo_dv) begin
         if (exp_q.size() == 0) check("sb_pop_without_expected", 32'd0, 32'd1);
         else check("sb_pop_data", fifo_d, exp_q.pop_front());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; fifo_rd = 1'b0; clear = 1'b0;
      cyc(); cyc();
      check("reset_ready",     32'(s_ready),   32'd0);
      check("reset_cnt",       32'(fifo_cnt),  32'd0);
      check("reset_dv",        32'(fifo_dv),   32'd0);
      check("reset_underflow", 32'(underflow), 32'd0);
      rst = 1'b0;
      cyc();
      check("ready_after_reset", 32'(s_ready), 32'd1);

      // Fill: words 1..5 offered, only 4 fit.
      s_valid = 1'b1; s_data = 32'd1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         check("fill_cnt",   32'(fifo_cnt), 32'(k));
         check("fill_ready", 32'(s_ready),  (k < 4) ? 32'd1 : 32'd0);
         s_data = 32'(k + 1);
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("full_hold_cnt",   32'(fifo_cnt), 32'd4);
         check("full_hold_ready", 32'(s_ready),  32'd0);
         check("full_head",       fifo_d,        32'd1);
      end
      s_valid = 1'b0;

      // Drain: 1,2,3,4 checked by the monitor; ready rises after the first pop.
      fifo_rd = 1'b1;
      for (int k = 3; k >= 0; k--) begin
         cyc();
         check("drain_cnt",   32'(fifo_cnt), 32'(k));
         check("drain_ready", 32'(s_ready),  32'd1);
      end
      check("drain_dv", 32'(fifo_dv), 32'd0);
      fifo_rd = 1'b0;

      // Concurrent push/pop at cnt=2 with an incrementing pattern; pointers wrap.
      s_valid = 1'b1; s_data = 32'h10;
      cyc(); s_data = 32'h11;
      cyc();
      check("pre_concurrent_cnt", 32'(fifo_cnt), 32'd2);
      fifo_rd = 1'b1; s_data = 32'h12;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("concurrent_cnt", 32'(fifo_cnt), 32'd2);
         s_data = 32'(32'h13 + i);
      end
      s_valid = 1'b0;
      cyc(); cyc();
      check("concurrent_drained_cnt", 32'(fifo_cnt), 32'd0);
      fifo_rd = 1'b0;

      // Underflow: read on empty is ignored and sticky until clear.
      fifo_rd = 1'b1;
      cyc();
      fifo_rd = 1'b0;
      check("underflow_set", 32'(underflow), 32'd1);
      check("underflow_cnt", 32'(fifo_cnt),  32'd0);
      cyc();
      check("underflow_sticky", 32'(underflow), 32'd1);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      check("underflow_cleared", 32'(underflow), 32'd0);

      // Clear with a simultaneous push at cnt=3: push is dropped.
      s_valid = 1'b1; s_data = 32'h20;
      cyc(); s_data = 32'h21;
      cyc(); s_data = 32'h22;
      cyc();
      check("pre_clear_cnt", 32'(fifo_cnt), 32'd3);
      clear = 1'b1; s_data = 32'h23;
      cyc();
      clear = 1'b0;
      check("clear_cnt",   32'(fifo_cnt), 32'd0);
      check("clear_dv",    32'(fifo_dv),  32'd0);
      check("clear_ready", 32'(s_ready),  32'd1);
      s_data = 32'h30;
      cyc();
      s_valid = 1'b0;
      check("post_clear_cnt",  32'(fifo_cnt), 32'd1);
      check("post_clear_head", fifo_d,        32'h30);
      fifo_rd = 1'b1;
      cyc();
      fifo_rd = 1'b0;
      check("post_clear_empty", 32'(fifo_cnt), 32'd0);

      // Reset mid-operation at cnt=3 with push active.
      s_valid = 1'b1; s_data = 32'h40;
      cyc(); s_data = 32'h41;
      cyc(); s_data = 32'h42;
      cyc();
      check("pre_reset_cnt", 32'(fifo_cnt), 32'd3);
      rst = 1'b1; s_data = 32'h43;
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("mid_reset_ready", 32'(s_ready),  32'd0);
         check("mid_reset_cnt",   32'(fifo_cnt), 32'd0);
         check("mid_reset_dv",    32'(fifo_dv),  32'd0);
      end
      rst = 1'b0; s_valid = 1'b0;
      cyc();
      check("post_reset_ready", 32'(s_ready),  32'd1);
      check("post_reset_cnt",   32'(fifo_cnt), 32'd0);
      s_valid = 1'b1; s_data = 32'hA5A5A5A5;
      cyc();
      s_valid = 1'b0;
      check("a5_cnt",  32'(fifo_cnt), 32'd1);
      check("a5_dv",   32'(fifo_dv),  32'd1);
      check("a5_head", fifo_d,        32'hA5A5A5A5);
      fifo_rd = 1'b1;
      cyc();
      fifo_rd = 1'b0;
      check("a5_drained_cnt", 32'(fifo_cnt), 32'd0);

      cyc(); cyc();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
